aria_stream_chain: RTL and testbench

- Streaming front-end that feeds the ARIA core (key schedule plus round datapath) and consumes its result.
- Accepts 128-bit blocks on a valid/ready input stream and applies ECB or CBC chaining around a single-block core run.
- Drives core_run/core_in, waits for the core's ready handshake, and presents chained results on a valid/ready output stream.
- Sits between the system bus adapter and the ARIA core top.

---
 rtl/aria_pkg.sv | 17 +
 rtl/aria_chain_xor.sv | 23 ++
 rtl/aria_stream_chain.sv | 148 ++++++++++++++
 tb/tb_aria_stream_chain.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/aria_pkg.sv
// aria_pkg: shared widths, key-length mode codes and front-end FSM state encodings
//   BLK_W / KEY_W         : block and key widths
//   ARIA_MODE_*           : cfg_mode codes (128/192/256-bit key, reserved)
//   ST_*                  : aria_stream_chain state encodings
package aria_pkg;
  localparam int BLK_W = 128;
  localparam int KEY_W = 256;
  localparam logic [1:0] ARIA_MODE_128 = 2'b00;
  localparam logic [1:0] ARIA_MODE_192 = 2'b01;
  localparam logic [1:0] ARIA_MODE_256 = 2'b10;
  localparam logic [1:0] ARIA_MODE_RSV = 2'b11;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_WAIT_LO = 3'd2;
  localparam logic [2:0] ST_WAIT_HI = 3'd3;
  localparam logic [2:0] ST_OUT     = 3'd4;
endpackage

// File: rtl/aria_chain_xor.sv
// aria_chain_xor: ECB/CBC pre-core XOR, post-core XOR and next chain value
//   i_cbc, i_dec   : chaining mode and direction of the current message
//   i_blk          : captured input block (plaintext or ciphertext)
//   i_chain        : current chain register
//   i_core_msg     : core result
//   o_core_in      : block presented to the core
//   o_m_data       : block presented on the output stream
//   o_chain_nxt    : chain value to commit once the output beat is taken
module aria_chain_xor import aria_pkg::*; (
  input  logic             i_cbc,
  input  logic             i_dec,
  input  logic [BLK_W-1:0] i_blk,
  input  logic [BLK_W-1:0] i_chain,
  input  logic [BLK_W-1:0] i_core_msg,
  output logic [BLK_W-1:0] o_core_in,
  output logic [BLK_W-1:0] o_m_data,
  output logic [BLK_W-1:0] o_chain_nxt
);
  assign o_core_in   = (i_cbc && !i_dec) ? i_blk ^ i_chain : i_blk;
  assign o_m_data    = (i_cbc && i_dec) ? i_core_msg ^ i_chain : i_core_msg;
  // encrypt chains on the produced ciphertext, decrypt on the consumed ciphertext
  assign o_chain_nxt = i_dec ? i_blk : i_core_msg;
endmodule

// File: rtl/aria_stream_chain.sv
// aria_stream_chain: valid/ready stream front-end running one ARIA core block at a time with ECB/CBC chaining
//   cfg_mode/cfg_cbc/cfg_decrypt/key : message config, captured on the first beat
//   iv/iv_load                       : CBC initial vector, loaded between messages
//   s_valid/s_ready/s_data/s_last    : input block stream
//   m_valid/m_ready/m_data/m_last    : output block stream
//   core_*                           : start pulse, config and block to the core; result and ready from it
//   busy/err                         : activity flag; pulse on reserved mode or watchdog expiry
module aria_stream_chain import aria_pkg::*; #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_cbc,
  input  logic             cfg_decrypt,
  input  logic [KEY_W-1:0] key,
  input  logic [BLK_W-1:0] iv,
  input  logic             iv_load,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [BLK_W-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [BLK_W-1:0] m_data,
  output logic             m_last,
  output logic             core_run,
  output logic [1:0]       core_mode,
  output logic             core_decrypt,
  output logic [KEY_W-1:0] core_key,
  output logic [BLK_W-1:0] core_in,
  input  logic [BLK_W-1:0] core_msg,
  input  logic             core_ready,
  output logic             busy,
  output logic             err
);
  logic [2:0]       r_state, w_nxt;
  logic             r_live, r_in_msg, r_cbc, r_dec, r_last, r_err;
  logic [1:0]       r_mode;
  logic [KEY_W-1:0] r_key;
  logic [BLK_W-1:0] r_blk, r_chain, r_chain_nxt, r_iv, r_mdata;
  logic [CNT_W-1:0] r_cnt;
  logic             w_acc, w_rsv, w_wait, w_done, w_tmo;
  logic [BLK_W-1:0] w_core_in, w_out, w_chain_nxt;

  aria_chain_xor u_xor (
    .i_cbc       (r_cbc),
    .i_dec       (r_dec),
    .i_blk       (r_blk),
    .i_chain     (r_chain),
    .i_core_msg  (core_msg),
    .o_core_in   (w_core_in),
    .o_m_data    (w_out),
    .o_chain_nxt (w_chain_nxt)
  );

  assign w_acc  = s_valid && s_ready;
  // mid-message the captured mode governs, so a reserved code appearing later is ignored
  assign w_rsv  = (r_in_msg ? r_mode : cfg_mode) == ARIA_MODE_RSV;
  assign w_wait = r_state == ST_WAIT_LO || r_state == ST_WAIT_HI;
  assign w_done = r_state == ST_WAIT_HI && core_ready;
  // watchdog fires only when the awaited core_ready level has not arrived
  assign w_tmo  = w_wait && r_cnt == CNT_W'(TIMEOUT_CYC - 1) &&
                  (r_state == ST_WAIT_LO ? core_ready : !core_ready);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:    w_nxt = w_acc ? (w_rsv ? ST_OUT : ST_RUN) : ST_IDLE;
      ST_RUN:     w_nxt = ST_WAIT_LO;
      ST_WAIT_LO: w_nxt = !core_ready ? ST_WAIT_HI : (w_tmo ? ST_OUT : ST_WAIT_LO);
      ST_WAIT_HI: w_nxt = (core_ready || w_tmo) ? ST_OUT : ST_WAIT_HI;
      ST_OUT:     w_nxt = m_ready ? ST_IDLE : ST_OUT;
      default:    w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_live      <= 1'b0;
      r_in_msg    <= 1'b0;
      r_cbc       <= 1'b0;
      r_dec       <= 1'b0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
      r_mode      <= '0;
      r_key       <= '0;
      r_blk       <= '0;
      r_chain     <= '0;
      r_chain_nxt <= '0;
      r_iv        <= '0;
      r_mdata     <= '0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_nxt;
      r_live  <= 1'b1;
      r_err   <= 1'b0;
      r_cnt   <= (w_wait && w_nxt == r_state) ? r_cnt + CNT_W'(1) : '0;
      if (w_acc) begin
        r_blk    <= s_data;
        r_last   <= s_last;
        r_in_msg <= !s_last;
        if (!r_in_msg) begin
          r_mode <= cfg_mode;
          r_cbc  <= cfg_cbc;
          r_dec  <= cfg_decrypt;
          r_key  <= key;
        end
        if (w_rsv) begin
          r_mdata     <= '0;
          r_err       <= 1'b1;
          r_chain_nxt <= s_last ? r_iv : r_chain;
        end
      end
      // chain commit is staged so it only lands when the result is actually taken
      if (w_done) begin
        r_mdata     <= w_out;
        r_chain_nxt <= r_last ? r_iv : (r_cbc ? w_chain_nxt : r_chain);
      end
      if (w_tmo) begin
        r_mdata     <= '0;
        r_err       <= 1'b1;
        r_in_msg    <= 1'b0;
        r_chain_nxt <= r_iv;
      end
      if (m_valid && m_ready) r_chain <= r_chain_nxt;
      if (iv_load && r_state == ST_IDLE && !r_in_msg) begin
        r_iv    <= iv;
        r_chain <= iv;
      end
    end
  end

  // r_live keeps s_ready low while in reset and for the first cycle after it
  assign s_ready      = r_live && r_state == ST_IDLE;
  assign m_valid      = r_state == ST_OUT;
  assign m_data       = r_mdata;
  assign m_last       = r_last;
  assign core_run     = r_state == ST_RUN;
  assign core_mode    = r_mode;
  assign core_decrypt = r_dec;
  assign core_key     = r_key;
  assign core_in      = w_core_in;
  assign busy         = r_state != ST_IDLE || r_in_msg;
  assign err          = r_err;
endmodule

// File: tb/tb_aria_stream_chain.sv
// tb_aria_stream_chain: directed bench with a stub core around aria_stream_chain
module tb_aria_stream_chain;
  localparam int TMO = 64;
  localparam logic [127:0] P  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C  = 128'hd718fbd6ab644c739da95f3be6451778;
  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IV2 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

  logic clk = 0, rst_n = 0;
  logic [1:0] cfg_mode = 0;
  logic cfg_cbc = 0, cfg_decrypt = 0, iv_load = 0;
  logic [255:0] key = {K, 128'h0};
  logic [127:0] iv = 0, s_data = 0, m_data, core_in, core_msg;
  logic s_valid = 0, s_ready, s_last = 0, m_valid, m_ready = 0, m_last;
  logic core_run, core_decrypt, core_ready, busy, err;
  logic [1:0] core_mode;
  logic [255:0] core_key;
  int checks = 0, failures = 0, runs = 0, errs = 0, lat_cyc = 4, cc = 0;
  logic dead = 0;

  aria_stream_chain #(.TIMEOUT_CYC(TMO), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_cbc(cfg_cbc),
    .cfg_decrypt(cfg_decrypt), .key(key), .iv(iv), .iv_load(iv_load),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_run(core_run), .core_mode(core_mode), .core_decrypt(core_decrypt),
    .core_key(core_key), .core_in(core_in), .core_msg(core_msg),
    .core_ready(core_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // stand-in cipher: the published ARIA-128 pair maps exactly, everything else is an invertible rotate/xor
  function automatic logic [127:0] fenc(input logic [127:0] x, input logic [127:0] k);
    return (x == P) ? C : ({x[126:0], x[127]} ^ k);
  endfunction
  function automatic logic [127:0] fdec(input logic [127:0] x, input logic [127:0] k);
    logic [127:0] t;
    t = x ^ k;
    return (x == C) ? P : {t[0], t[127:1]};
  endfunction

  // stub core: ready drops the edge after core_run, rises lat_cyc edges later with the result
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      core_ready <= 1'b1;
      core_msg   <= '0;
      cc         <= 0;
    end else if (core_run) begin
      core_ready <= 1'b0;
      cc         <= dead ? 0 : lat_cyc;
    end else if (cc != 0) begin
      cc <= cc - 1;
      if (cc == 1) begin
        core_ready <= 1'b1;
        core_msg   <= core_decrypt ? fdec(core_in, core_key[255:128]) : fenc(core_in, core_key[255:128]);
      end
    end

  always @(posedge clk) begin
    if (core_run) runs <= runs + 1;
    if (err) errs <= errs + 1;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [127:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_wait", 256'(s_ready), 256'(1));
    s_valid = 1;
    s_data  = d;
    s_last  = l;
    @(posedge clk);
    #1 s_valid = 0;
  endtask

  // lat counts clock edges from the accept edge until m_valid is seen
  task automatic recv(input string tag, input logic [127:0] d, input logic l, output int lat);
    lat = 0;
    while (!m_valid && lat < 300) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk({tag, "_valid"}, 256'(m_valid), 256'(1));
    chk({tag, "_data"}, 256'(m_data), 256'(d));
    chk({tag, "_last"}, 256'(m_last), 256'(l));
    @(negedge clk) m_ready = 1;
    @(posedge clk);
    #1 m_ready = 0;
  endtask

  task automatic load_iv(input logic [127:0] v);
    @(negedge clk);
    iv = v;
    iv_load = 1;
    @(posedge clk);
    #1 iv_load = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 256'({s_ready, m_valid, m_last, core_run, core_decrypt, busy, err, core_mode}), 256'(0));
    chk({tag, "_mdata"}, 256'(m_data), 256'(0));
    chk({tag, "_corein"}, 256'(core_in), 256'(0));
    chk({tag, "_key"}, core_key, 256'(0));
  endtask

  initial begin
    int lat, r0, e0;
    logic [127:0] c2;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1;

    // ECB encrypt, latency = accept cycle + lat_cyc + 2 edges
    r0 = runs;
    send(P, 1);
    chk("ecb_key", core_key, {K, 128'h0});
    chk("ecb_corein", 256'(core_in), 256'(P));
    recv("ecb", C, 1, lat);
    chk("ecb_lat", 256'(lat), 256'(lat_cyc + 2));
    chk("ecb_runs", 256'(runs - r0), 256'(1));
    chk("ecb_busy", 256'(busy), 256'(0));

    // CBC encrypt, two blocks; cfg_decrypt flipped mid-message must be ignored
    cfg_cbc = 1;
    load_iv(0);
    send(P, 0);
    recv("cbce1", C, 0, lat);
    chk("cbce_busy", 256'(busy), 256'(1));
    cfg_decrypt = 1;
    send(P, 1);
    chk("cbce2_corein", 256'(core_in), 256'(P ^ C));
    c2 = fenc(P ^ C, K);
    recv("cbce2", c2, 1, lat);

    // CBC decrypt of the two ciphertexts with the same iv
    send(C, 0);
    chk("cbcd_dec", 256'(core_decrypt), 256'(1));
    recv("cbcd1", P, 0, lat);
    send(c2, 1);
    chk("cbcd2_corein", 256'(core_in), 256'(c2));
    recv("cbcd2", P, 1, lat);

    // back-pressure with 192-bit mode code captured
    cfg_cbc = 0;
    cfg_decrypt = 0;
    cfg_mode = 2'b01;
    send(P, 1);
    chk("bp_mode", 256'(core_mode), 256'(1));
    lat = 0;
    while (!m_valid && lat < 300) begin
      @(posedge clk);
      lat++;
      #1;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 256'(m_valid), 256'(1));
      chk("bp_data", 256'(m_data), 256'(C));
      chk("bp_sready", 256'(s_ready), 256'(0));
    end
    recv("bp", C, 1, lat);
    chk("bp_release_sready", 256'(s_ready), 256'(1));

    // reserved mode: err, zero data, no core run, back to idle
    cfg_mode = 2'b11;
    r0 = runs;
    e0 = errs;
    send(P, 1);
    recv("rsv", 0, 1, lat);
    chk("rsv_runs", 256'(runs - r0), 256'(0));
    chk("rsv_errs", 256'(errs - e0), 256'(1));
    @(negedge clk);
    chk("rsv_idle", 256'({s_ready, busy}), 256'(2'b10));
    cfg_mode = 2'b00;

    // watchdog: core never returns; RUN + 1 WAIT_LO + TMO WAIT_HI cycles
    dead = 1;
    e0 = errs;
    send(P, 0);
    recv("tmo", 0, 0, lat);
    chk("tmo_lat", 256'(lat), 256'(TMO + 2));
    chk("tmo_errs", 256'(errs - e0), 256'(1));
    chk("tmo_inmsg", 256'(busy), 256'(0));
    dead = 0;

    // reset while waiting for core_ready high
    lat_cyc = 10;
    send(P, 1);
    repeat (4) @(posedge clk);
    #1 chk("wait_hi_busy", 256'({busy, core_run, m_valid}), 256'(3'b100));
    @(negedge clk) rst_n = 0;
    @(posedge clk);
    #1 chk_zero("midrst");
    @(negedge clk) rst_n = 1;
    lat_cyc = 4;

    // iv_load during a message is ignored; a load between messages takes effect
    cfg_cbc = 1;
    send(P, 0);
    recv("iv1", C, 0, lat);
    load_iv(IV2);
    send(P, 1);
    chk("iv_mid_corein", 256'(core_in), 256'(P ^ C));
    recv("iv2", fenc(P ^ C, K), 1, lat);
    send(P, 1);
    chk("iv_reload_corein", 256'(core_in), 256'(P));
    recv("iv3", C, 1, lat);
    load_iv(IV2);
    send(P, 1);
    chk("iv_new_corein", 256'(core_in), 256'(P ^ IV2));
    recv("iv4", fenc(P ^ IV2, K), 1, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
